// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read-port bundle between the async UART FIFO (slave) and the draining transmitter (master).
interface uart_tx_fifo_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;

  modport master (input fifo_empty, input fifo_data, output fifo_rd);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter popping bytes from a first-word-fall-through FIFO and
// framing them as start / data (LSB first) / optional parity / 1-2 stop bits.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  uart_tx_fifo_drain_if.master   fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   tx_done
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state;
  logic [BW-1:0]         baud_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  stop_cnt;
  logic                  bit_end;
  logic                  last_stop;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (STOP_BITS == 1) || stop_cnt;

  // tx is registered, so every transition loads the level of the next bit
  // at the edge that ends the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      stop_cnt     <= 1'b0;
      tx           <= 1'b1;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      fifo.fifo_rd <= 1'b0;
    end else begin
      fifo.fifo_rd <= 1'b0;
      tx_done      <= 1'b0;
      if (state != S_IDLE)
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            // Head word is captured now; the pop lands one edge later.
            shreg        <= fifo.fifo_data;
            par_bit      <= (PARITY == 1) ? ~^fifo.fifo_data : ^fifo.fifo_data;
            state        <= S_START;
            busy         <= 1'b1;
            tx           <= 1'b0;
            fifo.fifo_rd <= 1'b1;
            baud_cnt     <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx    <= par_bit;
              end else begin
                state    <= S_STOP;
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          // Raised one edge early so the pulse lines up with the final cycle.
          if (last_stop && baud_cnt == BAUD_PRE)
            tx_done <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
